// File: rtl/run_sequencer.sv
// Sequences a processor through reset, then NUM_PROGS launch/run/report passes, with a per-run timeout.
// Optional feature: define RUN_SEQ_TOTAL_EN to add the 24-bit saturating TotalCount output.
module run_sequencer #(
  parameter int          NUM_PROGS   = 3,
  parameter int          RST_CYC     = 2,
  parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic        Ack,
  output logic        DutReset,
  output logic        DutStart,
  output logic [1:0]  ProgIdx,
  output logic        Busy,
  output logic        CountValid,
  output logic [15:0] CycleCount,
  output logic        Done,
  output logic        Timeout
`ifdef RUN_SEQ_TOTAL_EN
  ,
  output logic [23:0] TotalCount
`endif
);

  typedef enum logic [2:0] {IDLE, RST, LAUNCH, RUN, REPORT, FIN} state_t;

  state_t      state, state_nx;
  logic [3:0]  rst_cnt;
  logic [15:0] run_cnt;
  logic [15:0] run_inc;
  logic        ack_q;
  logic        tmo_hit;
  logic        last_prog;

  // run_inc is the RUN cycle count including the current cycle
  assign run_inc   = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
  // run_cnt is 0 only in the first RUN cycle, where a leftover Ack must not count
  assign ack_q     = Ack && (run_cnt != 16'd0);
  assign tmo_hit   = (run_inc == TIMEOUT_CYC);
  assign last_prog = (ProgIdx == 2'(NUM_PROGS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Go) state_nx = RST;
      RST:     if (rst_cnt == 4'(RST_CYC - 1)) state_nx = LAUNCH;
      LAUNCH:  state_nx = RUN;
      RUN:     if (ack_q || tmo_hit) state_nx = REPORT;
      REPORT:  state_nx = (Timeout || last_prog) ? FIN : LAUNCH;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef RUN_SEQ_TOTAL_EN
  logic [24:0] total_sum;
  assign total_sum = {1'b0, TotalCount} + {9'd0, CycleCount};
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      DutReset   <= 1'b1;
      DutStart   <= 1'b0;
      ProgIdx    <= 2'd0;
      Busy       <= 1'b0;
      CountValid <= 1'b0;
      CycleCount <= 16'd0;
      Done       <= 1'b0;
      Timeout    <= 1'b0;
      rst_cnt    <= 4'd0;
      run_cnt    <= 16'd0;
`ifdef RUN_SEQ_TOTAL_EN
      TotalCount <= 24'd0;
`endif
    end else begin
      state      <= state_nx;
      // Outputs are decoded from the next state so they line up with the registered state
      DutReset   <= (state_nx == RST);
      DutStart   <= (state_nx == LAUNCH);
      Busy       <= (state_nx != IDLE);
      CountValid <= (state_nx == REPORT);
      Done       <= (state_nx == FIN);
      case (state)
        IDLE: if (Go) begin
          ProgIdx <= 2'd0;
          Timeout <= 1'b0;
          rst_cnt <= 4'd0;
`ifdef RUN_SEQ_TOTAL_EN
          TotalCount <= 24'd0;
`endif
        end
        RST:    rst_cnt <= rst_cnt + 4'd1;
        LAUNCH: run_cnt <= 16'd0;
        RUN: begin
          run_cnt <= run_inc;
          if (ack_q) CycleCount <= run_inc;
          else if (tmo_hit) begin
            CycleCount <= TIMEOUT_CYC;
            Timeout    <= 1'b1;
          end
        end
        REPORT: begin
          if (!(Timeout || last_prog)) ProgIdx <= ProgIdx + 2'd1;
`ifdef RUN_SEQ_TOTAL_EN
          TotalCount <= total_sum[24] ? 24'hFFFFFF : total_sum[23:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_PROGS, 3: programs run per sequence, range 1..4.
- RST_CYC, 2: cycles DutReset is held per sequence, range 1..15.
- TIMEOUT_CYC, 16'd60000: RUN cycles before abort, range 2..65535.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- Clk, in, 1: clock; posedge used.
- Reset, in, 1: asynchronous, active-high reset.
- Go, in, 1: request to start a sequence.
- Ack, in, 1: done flag from the processor.
- DutReset, out, 1: processor reset.
- DutStart, out, 1: processor start.
- ProgIdx, out, 2: index of the current program.
- Busy, out, 1: sequence in progress.
- CountValid, out, 1: one-cycle pulse; CycleCount is valid.
- CycleCount, out, 16: RUN cycles of the last program.
- Done, out, 1: one-cycle end-of-sequence pulse.
- Timeout, out, 1: sticky abort flag.

Function
REQ-003 The FSM SHALL have states IDLE, RST, LAUNCH, RUN, REPORT and FIN, and all outputs SHALL be registered.
REQ-004 In IDLE, Go=1 SHALL cause the following on the next edge: go to RST, ProgIdx=0, Timeout=0, reset-cycle counter=0.
REQ-005 Go SHALL be ignored in all states other than IDLE.
REQ-006 RST SHALL hold DutReset=1 for exactly RST_CYC cycles and then go to LAUNCH.
REQ-007 LAUNCH SHALL last exactly 1 cycle with DutStart=1, then go to RUN with the run counter cleared to 0.
REQ-008 In RUN, the run counter SHALL increment by 1 every cycle and saturate at 16'hFFFF.
REQ-009 Ack SHALL be ignored in the first RUN cycle, so that a stale Ack from the previous program does not end the run.
REQ-010 From the second RUN cycle on, Ack=1 SHALL cause a transition to REPORT, with CycleCount = number of RUN cycles including the Ack cycle.
REQ-011 When the run counter reaches TIMEOUT_CYC without a qualifying Ack, the block SHALL set Timeout=1, set CycleCount=TIMEOUT_CYC, and go to REPORT.
REQ-012 If a qualifying Ack and the timeout occur in the same cycle, Ack SHALL win and Timeout SHALL stay 0.
REQ-013 REPORT SHALL last 1 cycle with CountValid=1.
REQ-014 On leaving REPORT, the block SHALL go to FIN if Timeout=1 or ProgIdx==NUM_PROGS-1.
REQ-015 Otherwise, on leaving REPORT, the block SHALL increment ProgIdx and go to LAUNCH; DutReset SHALL NOT be re-asserted between programs.
REQ-016 FIN SHALL last 1 cycle with Done=1, then go to IDLE.
REQ-017 Busy SHALL be 1 in every state except IDLE.
REQ-018 CycleCount, ProgIdx and Timeout SHALL hold their values in IDLE until the next accepted Go.
REQ-019 With NUM_PROGS=1, the sequence SHALL be RST, LAUNCH, RUN, REPORT, FIN.

Reset
REQ-020 Reset=1 SHALL asynchronously force: state=IDLE, DutReset=1, DutStart=0, ProgIdx=0, Busy=0, CountValid=0, CycleCount=0, Done=0, Timeout=0, and clear all counters.
REQ-021 DutReset SHALL fall to 0 on the first Clk edge after Reset deasserts.
REQ-022 Reset asserted mid-sequence SHALL abort the sequence with no Done or CountValid pulse.
REQ-023 If Go and Reset are both 1, Reset SHALL win.

Configuration
REQ-024 With RUN_SEQ_TOTAL_EN defined, the block SHALL add output TotalCount, 24 bits, with this behaviour:
- cleared to 0 on reset and on an accepted Go;
- in each REPORT cycle, CycleCount is added, saturating at 24'hFFFFFF.
REQ-025 With RUN_SEQ_TOTAL_EN undefined, the TotalCount port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover the following directed scenarios (stimulus -> required response):
- Nominal: defaults; Ack at RUN cycles 10/20/30 -> three CountValid pulses with CycleCount=10,20,30 and ProgIdx=0,1,2; Done 1 cycle after the third REPORT; Timeout=0.
- Stale Ack: Ack held at 1 through LAUNCH and the first RUN cycle, then 0, then 1 at RUN cycle 5 -> CycleCount=5.
- Timeout: TIMEOUT_CYC=8, Ack never set -> CycleCount=8, Timeout=1, Done with ProgIdx=0; no further DutStart.
- Reset mid-RUN (program 1, cycle 4): Reset=1 -> same cycle IDLE, DutReset=1, Busy=0; no Done.
- Go while Busy -> ignored; Go=1 in the FIN cycle -> ignored, then Go in IDLE restarts with DutReset=1 for exactly RST_CYC=2 cycles.
- RUN_SEQ_TOTAL_EN defined, nominal run -> TotalCount=60 after Done.
